// File: rtl/ycr_pipe_pkg.sv
// Shared types and helpers for the pipe sleep/wake sequencer.
package ycr_pipe_pkg;

  localparam int YCR_SLPCTL_RESUME_DLY_MAX = 15;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    DRAIN     = 3'd1,
    SLEEP_REQ = 3'd2,
    SLEEP     = 3'd3,
    WAKE      = 3'd4,
    RESUME    = 3'd5
  } type_ycr_slpctl_state_e;

  typedef struct packed {
    logic sleep_req;
    logic wake_req;
    logic fetch_stall;
    logic sleeping;
  } type_ycr_slpctl_out_s;

  // Output pattern owned by each state; undefined encodings decode to all-zero.
  function automatic type_ycr_slpctl_out_s ycr_slpctl_decode(input type_ycr_slpctl_state_e st);
    type_ycr_slpctl_out_s o;
    o = '{sleep_req: 1'b0, wake_req: 1'b0, fetch_stall: 1'b0, sleeping: 1'b0};
    case (st)
      RUN:       o.fetch_stall = 1'b0;
      DRAIN:     o.fetch_stall = 1'b1;
      SLEEP_REQ: begin
        o.fetch_stall = 1'b1;
        o.sleep_req   = 1'b1;
      end
      SLEEP:     begin
        o.fetch_stall = 1'b1;
        o.sleeping    = 1'b1;
      end
      WAKE:      begin
        o.fetch_stall = 1'b1;
        o.wake_req    = 1'b1;
      end
      RESUME:    o.fetch_stall = 1'b1;
      default:   o.fetch_stall = 1'b0;
    endcase
    return o;
  endfunction

  function automatic int ycr_slpctl_clamp_dly(input int dly);
    if (dly < 1) begin
      return 1;
    end else if (dly > YCR_SLPCTL_RESUME_DLY_MAX) begin
      return YCR_SLPCTL_RESUME_DLY_MAX;
    end else begin
      return dly;
    end
  endfunction

endpackage

// File: rtl/ycr_slpctl_dncnt.sv
// Loadable down-counter that saturates at zero; flags zero and the last step (1 -> 0).
module ycr_slpctl_dncnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] cnt_r;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {W{1'b0}});
  assign last = (cnt_r == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/ycr_pipe_sleep_ctrl.sv
// WFI sleep/wake sequencer feeding pipe clock control.
// Optional sleep timeout wake-up is built when YCR_SLEEP_TIMER_EN is defined.
module ycr_pipe_sleep_ctrl
  import ycr_pipe_pkg::*;
#(
  parameter int RESUME_DLY = 2,
  parameter int TMR_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic wfi_retire_i,
  input  logic irq_pending_i,
  input  logic dbg_halt_req_i,
  input  logic pipe_idle_i,
  input  logic clk_en_i,
  output logic sleep_req_o,
  output logic wake_req_o,
  output logic fetch_stall_o,
  output logic sleeping_o
`ifdef YCR_SLEEP_TIMER_EN
  ,
  input  logic [TMR_W-1:0] wake_tmo_i
`endif
);

  localparam int RSM_W = $clog2(YCR_SLPCTL_RESUME_DLY_MAX + 1);
  localparam logic [RSM_W-1:0] RSM_LOAD = RSM_W'(ycr_slpctl_clamp_dly(RESUME_DLY));

  type_ycr_slpctl_state_e state_r;
  type_ycr_slpctl_state_e nxt_state_s;
  type_ycr_slpctl_out_s   nxt_out_s;

  logic sleep_req_r;
  logic wake_req_r;
  logic fetch_stall_r;
  logic sleeping_r;

  logic wake_ev_s;
  logic tmr_expire_s;
  logic rsm_load_s;
  logic rsm_dec_s;
  logic rsm_zero_s;
  logic rsm_last_s;

`ifdef YCR_SLEEP_TIMER_EN
  logic tmr_load_s;
  logic tmr_dec_s;
  logic tmr_zero_s;
  logic tmr_last_s;

  // Timer is armed on every SLEEP entry; a zero load never reaches the last step.
  assign tmr_load_s   = (nxt_state_s == SLEEP) && (state_r != SLEEP);
  assign tmr_dec_s    = (state_r == SLEEP);
  assign tmr_expire_s = tmr_dec_s & tmr_last_s & ~tmr_zero_s;

  ycr_slpctl_dncnt #(
    .W (TMR_W)
  ) i_tmr_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (wake_tmo_i),
    .dec      (tmr_dec_s),
    .zero     (tmr_zero_s),
    .last     (tmr_last_s)
  );
`else
  assign tmr_expire_s = 1'b0;
`endif

  assign wake_ev_s  = irq_pending_i | dbg_halt_req_i | tmr_expire_s;
  assign rsm_load_s = (state_r == WAKE) && clk_en_i;
  assign rsm_dec_s  = (state_r == RESUME);

  ycr_slpctl_dncnt #(
    .W (RSM_W)
  ) i_rsm_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (rsm_load_s),
    .load_val (RSM_LOAD),
    .dec      (rsm_dec_s),
    .zero     (rsm_zero_s),
    .last     (rsm_last_s)
  );

  // Next-state selection; wake events beat drain completion and clock disable.
  always_comb begin
    nxt_state_s = state_r;
    case (state_r)
      RUN: begin
        if (wfi_retire_i && !wake_ev_s) begin
          nxt_state_s = DRAIN;
        end else begin
          nxt_state_s = RUN;
        end
      end
      DRAIN: begin
        if (wake_ev_s) begin
          nxt_state_s = RUN;
        end else if (pipe_idle_i) begin
          nxt_state_s = SLEEP_REQ;
        end else begin
          nxt_state_s = DRAIN;
        end
      end
      SLEEP_REQ: begin
        if (wake_ev_s) begin
          nxt_state_s = WAKE;
        end else if (!clk_en_i) begin
          nxt_state_s = SLEEP;
        end else begin
          nxt_state_s = SLEEP_REQ;
        end
      end
      SLEEP: begin
        if (wake_ev_s) begin
          nxt_state_s = WAKE;
        end else begin
          nxt_state_s = SLEEP;
        end
      end
      WAKE: begin
        if (clk_en_i) begin
          nxt_state_s = RESUME;
        end else begin
          nxt_state_s = WAKE;
        end
      end
      RESUME: begin
        if (rsm_last_s || rsm_zero_s) begin
          nxt_state_s = RUN;
        end else begin
          nxt_state_s = RESUME;
        end
      end
      default: nxt_state_s = RUN;
    endcase
  end

  assign nxt_out_s = ycr_slpctl_decode(nxt_state_s);

  // State and outputs update together so outputs always match the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= RUN;
      sleep_req_r   <= 1'b0;
      wake_req_r    <= 1'b0;
      fetch_stall_r <= 1'b0;
      sleeping_r    <= 1'b0;
    end else begin
      state_r       <= nxt_state_s;
      sleep_req_r   <= nxt_out_s.sleep_req;
      wake_req_r    <= nxt_out_s.wake_req;
      fetch_stall_r <= nxt_out_s.fetch_stall;
      sleeping_r    <= nxt_out_s.sleeping;
    end
  end

  assign sleep_req_o   = sleep_req_r;
  assign wake_req_o    = wake_req_r;
  assign fetch_stall_o = fetch_stall_r;
  assign sleeping_o    = sleeping_r;

endmodule

// File: tb/tb_ycr_pipe_sleep_ctrl.sv
// Self-checking bench: vector table, corner-case sequences, random run against a phase model.
module tb_ycr_pipe_sleep_ctrl;

  localparam int RESUME_DLY = 2;
  localparam int TMR_W      = 16;
`ifdef YCR_SLEEP_TIMER_EN
  localparam bit TMR_EN = 1'b1;
`else
  localparam bit TMR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic wfi, irq, dbg, idle, ce;
  logic sleep_req, wake_req, fetch_stall, sleeping;
  logic [TMR_W-1:0] wake_tmo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ycr_pipe_sleep_ctrl #(
    .RESUME_DLY (RESUME_DLY),
    .TMR_W      (TMR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wfi_retire_i   (wfi),
    .irq_pending_i  (irq),
    .dbg_halt_req_i (dbg),
    .pipe_idle_i    (idle),
    .clk_en_i       (ce),
    .sleep_req_o    (sleep_req),
    .wake_req_o     (wake_req),
    .fetch_stall_o  (fetch_stall),
    .sleeping_o     (sleeping)
`ifdef YCR_SLEEP_TIMER_EN
    ,
    .wake_tmo_i     (wake_tmo)
`endif
  );

  // outputs packed as {sleep_req, wake_req, fetch_stall, sleeping}
  function automatic logic [3:0] outs();
    return {sleep_req, wake_req, fetch_stall, sleeping};
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (sreq,wreq,stall,sleeping)", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic i, input logic d, input logic p, input logic c);
    wfi = w; irq = i; dbg = d; idle = p; ce = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    m_reset();
  endtask

  // Behavioural model: phase 0 run, 1 draining, 2 asking to sleep, 3 asleep, 4 asking to wake, 5 resuming
  int m_ph, m_rsm_left, m_tmr_left, m_tmo;

  task automatic m_reset();
    m_ph = 0; m_rsm_left = 0; m_tmr_left = 0;
  endtask

  task automatic m_step();
    bit fire, wake;
    fire = TMR_EN && (m_ph == 3) && (m_tmr_left == 1);
    wake = irq || dbg || fire;
    if (m_ph == 3 && m_tmr_left > 0) m_tmr_left--;
    if (m_ph == 0) begin
      if (wfi && !wake) m_ph = 1;
    end else if (m_ph == 1) begin
      if (wake) m_ph = 0;
      else if (idle) m_ph = 2;
    end else if (m_ph == 2) begin
      if (wake) m_ph = 4;
      else if (!ce) begin
        m_ph = 3;
        m_tmr_left = m_tmo;
      end
    end else if (m_ph == 3) begin
      if (wake) m_ph = 4;
    end else if (m_ph == 4) begin
      if (ce) begin
        m_ph = 5;
        m_rsm_left = RESUME_DLY;
      end
    end else begin
      m_rsm_left--;
      if (m_rsm_left == 0) m_ph = 0;
    end
  endtask

  function automatic logic [3:0] m_outs();
    return {m_ph == 2, m_ph == 4, m_ph != 0, m_ph == 3};
  endfunction

  typedef struct {
    logic wfi, irq, dbg, idle, ce;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int viol;
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1010};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1010};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0011};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0011};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0110};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0110};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0010};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0010};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000};

    m_tmo = 0;
    wake_tmo = '0;
    do_reset();
    chk("reset_state", outs(), 4'b0000);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].wfi, vecs[i].irq, vecs[i].dbg, vecs[i].idle, vecs[i].ce);
      tick();
      chk($sformatf("vec[%0d]", i), outs(), vecs[i].exp);
    end

    // drain abort: pipe busy for 5 cycles, then debug halt request
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("drain_enter", outs(), 4'b0010);
    wfi = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("drain_hold[%0d]", i), outs(), 4'b0010);
    end
    dbg = 1'b1;
    tick();
    chk("drain_abort", outs(), 4'b0000);
    dbg = 1'b0;
    tick();
    chk("drain_abort_run", outs(), 4'b0000);

    // race: wake event in the same cycle the clock enable falls
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    wfi = 1'b0;
    tick();
    chk("race_sreq", outs(), 4'b1010);
    irq = 1'b1; ce = 1'b0;
    tick();
    chk("race_wake", outs(), 4'b0110);
    tick();
    chk("race_wake_hold", outs(), 4'b0110);
    ce = 1'b1;
    tick();
    chk("race_resume0", outs(), 4'b0010);
    irq = 1'b0;
    tick();
    chk("race_resume1", outs(), 4'b0010);
    tick();
    chk("race_run", outs(), 4'b0000);

    // asynchronous reset while asleep
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    wfi = 1'b0;
    tick();
    ce = 1'b0;
    tick();
    chk("rst_pre_sleep", outs(), 4'b0011);
    #2 rst = 1'b1;
    #1;
    chk("rst_async", outs(), 4'b0000);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_release", outs(), 4'b0000);
    wfi = 1'b1;
    tick();
    chk("rst_then_wfi", outs(), 4'b0010);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    chk("rst_then_abort", outs(), 4'b0000);
    dbg = 1'b0;

`ifdef YCR_SLEEP_TIMER_EN
    // timeout of 10 sleep cycles raises wake_req
    wake_tmo = 16'd10;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    wfi = 1'b0;
    tick();
    ce = 1'b0;
    tick();
    chk("tmr_sleep", outs(), 4'b0011);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("tmr_wait[%0d]", i), outs(), 4'b0011);
    end
    tick();
    chk("tmr_expire", outs(), 4'b0110);
    ce = 1'b1;
    repeat (3) tick();
    chk("tmr_back_run", outs(), 4'b0000);

    // zero timeout never wakes
    wake_tmo = 16'd0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    wfi = 1'b0;
    tick();
    ce = 1'b0;
    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (outs() !== 4'b0011) viol++;
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL tmr_zero_no_wake: %0d cycles left sleep, required 0", viol);
    end
    irq = 1'b1;
    tick();
    chk("tmr_zero_irq_wake", outs(), 4'b0110);
    ce = 1'b1; irq = 1'b0;
    repeat (3) tick();
    chk("tmr_zero_run", outs(), 4'b0000);
    m_tmo = 3;
    wake_tmo = 16'd3;
`endif

    // random stimulus against the phase model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(3) == 0, $urandom_range(9) == 0, $urandom_range(19) == 0,
            $urandom_range(3) != 0, $urandom_range(1) == 1);
      m_step();
      tick();
      chk($sformatf("rand[%0d]", n), outs(), m_outs());
      chk($sformatf("rand_excl[%0d]", n), {3'b000, sleep_req & wake_req}, 4'b0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
